// File: rtl/gen_agebuff.sv
// gen_agebuff: slot buffer with lowest-free allocation, mask pop and age-matrix oldest tracking
module gen_agebuff #(
  parameter int DW = 64,
  parameter int DP = 8,
  parameter int CW = $clog2(DP+1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [DW-1:0]         info_i,
  output logic                  push_rdy,
  output logic [$clog2(DP)-1:0] alloc_idx,
  input  logic [DP-1:0]         pop_mask,
  input  logic                  flush,
  output logic [DW*DP-1:0]      info_o,
  output logic [DP-1:0]         valid,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic [$clog2(DP)-1:0] oldest_idx,
  output logic                  oldest_vld,
  output logic                  ovf_err
);
  localparam int AW = $clog2(DP);
  logic [DW-1:0] mem [DP];
  logic [DP-1:0] age [DP];
  logic [DP-1:0] blk;
  logic          acc;
  assign full     = count == CW'(DP);
  assign empty    = count == '0;
  assign push_rdy = ~full;
  assign acc      = push & ~full & ~flush;
  for (genvar g = 0; g < DP; g++) assign info_o[DW*g +: DW] = mem[g];
  // occupancy and lowest free slot, both from registered valid only
  always_comb begin
    count     = '0;
    alloc_idx = '0;
    for (int n = DP-1; n >= 0; n--) begin
      count     = count + CW'(valid[n]);
      alloc_idx = valid[n] ? alloc_idx : AW'(n);
    end
  end
  // a slot is blocked when any valid slot is older than it; the unblocked valid slot is the oldest
  always_comb begin
    blk        = '0;
    oldest_idx = '0;
    oldest_vld = |valid;
    for (int i = 0; i < DP; i++)
      for (int j = 0; j < DP; j++)
        blk[i] = blk[i] | (valid[j] & age[j][i]);
    for (int i = DP-1; i >= 0; i--)
      oldest_idx = (valid[i] & ~blk[i]) ? AW'(i) : oldest_idx;
  end
  // slot payload is written on accepted push and never reset
  always_ff @(posedge CLK)
    if (acc) mem[alloc_idx] <= info_i;
  // valid bits, age matrix and sticky overflow; flush wins over push and pop
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      valid <= '0;
      for (int i = 0; i < DP; i++) age[i] <= '0;
      if (RST) ovf_err <= 1'b0;
    end else begin
      if (push && full) ovf_err <= 1'b1;
      valid <= (valid & ~pop_mask) | (acc ? DP'(1) << alloc_idx : '0);
      if (acc)
        for (int j = 0; j < DP; j++) begin
          if (valid[j]) age[j][alloc_idx] <= 1'b1;
          age[alloc_idx][j] <= 1'b0;
        end
    end
  end
endmodule

// File: doc/gen_agebuff.md
Name: gen_agebuff

Overview:
Parametrised successor to the indexed ping-pong buffer. A DP-entry slot buffer with per-slot valid bits and automatic lowest-free-slot allocation on push. Pop is by bitmask and may release any number of slots per cycle. An age matrix tracks insertion order and reports the oldest valid slot, so issue/commit stages can select in program order.

Parameters:
DW, 64, data width of one slot
DP, 8, number of slots (>=2, power of two not required)
CW, $clog2(DP+1), width of the occupancy count

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
push  input  1  write info_i into a free slot this cycle
info_i  input  DW  data to store on push
push_rdy  output  1  ~full; a push is accepted only when push_rdy=1
alloc_idx  output  $clog2(DP)  slot that an accepted push writes (lowest-index free slot)
pop_mask  input  DP  one bit per slot; clears the valid bit of each set slot
flush  input  1  invalidate all slots
info_o  output  DW*DP  all slot contents, slot n at [DW*n +: DW]
valid  output  DP  per-slot valid bits
count  output  CW  number of valid slots
empty  output  1  count==0
full  output  1  count==DP
oldest_idx  output  $clog2(DP)  index of the oldest valid slot
oldest_vld  output  1  at least one slot is valid (oldest_idx is meaningful)
ovf_err  output  1  sticky: a push arrived while full

Behaviour:
- Reset: the interface is one clock with synchronous active-high reset (RST), sampled on the CLK rising edge. Reset clears valid, the age matrix, ovf_err and count. After reset: empty=1, full=0, push_rdy=1, alloc_idx=0, oldest_vld=0, oldest_idx=0. Slot data is not reset; info_o content is undefined until written. Reset mid-operation discards all slots in the same edge.
- Allocation (combinational from current state): alloc_idx = lowest n with valid[n]=0. When full, alloc_idx=0 and no write occurs.
- Push accepted = push & ~full & ~flush. On an accepted push, at the next edge: slot alloc_idx <= info_i, valid[alloc_idx] <= 1.
- Pop: at the next edge, valid[n] <= 0 for each n with pop_mask[n]=1. Pop bits on already-invalid slots are ignored. Pop does not alter data.
- Simultaneous push and pop: allocation uses only slots free at the start of the cycle. A slot popped this cycle is not reused until the next cycle. A push and a pop can therefore never target the same slot, and count_next = count + accepted_push - popcount(pop_mask & valid).
- Push while full: dropped, state unchanged, ovf_err <= 1. ovf_err is cleared only by RST.
- Flush has highest priority. At the next edge all valid <= 0 and age state is cleared. Push and pop are ignored that cycle and ovf_err is not set.
- Age matrix: age[i][j]=1 means slot i is older than slot j (i != j). On an accepted push into slot k: age[j][k] <= 1 for every j valid at the start of the cycle, and age[k][j] <= 0 for all j. Pops leave the matrix untouched; entries of invalid slots are masked on use.
- Oldest: oldest_idx = the valid slot i for which no valid j has age[j][i]=1. The result is unique when the matrix is consistent. If no slot is valid, oldest_vld=0 and oldest_idx=0. All outputs except the registered state are combinational from registers: zero-cycle latency, and a newly pushed entry is visible the cycle after the push edge.
- count, full and empty are derived from registered valid. They are never driven by push or pop inputs combinationally.

Test Plan:
1. DW=8, DP=4, reset, then push 0xA1,0xB2,0xC3,0xD4 on consecutive cycles -> alloc_idx 0,1,2,3; valid=4'b1111, full=1, push_rdy=0, count=4, oldest_idx=0.
2. From full, push 0xEE -> no slot changes, ovf_err=1 and it stays 1 after later pops; RST clears it.
3. From full, pop_mask=4'b0101 -> valid=4'b1010, count=2, oldest_idx=1. Next push 0x55 -> alloc_idx=0; after it, oldest_idx stays 1 and slot0 is youngest.
4. valid=4'b0111, same cycle push 0x77 and pop_mask=4'b0001 -> write goes to slot3 (not slot0); result valid=4'b1110, count=3, oldest_idx=1.
5. With 3 valid slots, assert flush together with push and pop_mask=4'b1111 -> next cycle valid=0, empty=1, oldest_vld=0, ovf_err unchanged.
6. Out-of-order aging: push into slots 0,1,2; pop slot0; push (goes to 0); pop slot1 -> oldest_idx=2. Pop slot2 -> oldest_idx=0, the re-pushed slot.
